// File: rtl/sha_1_msg_feeder.sv
// rtl/sha_1_msg_feeder.sv - FIPS 180-4 padding and 512-bit block feeder for the SHA-1 core
module sha_1_msg_feeder #(
  parameter int START_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [15:0][31:0] blk_data,
  output logic              blk_start,
  output logic              blk_first,
  input  logic              blk_done,
  output logic              busy,
  output logic              msg_done
);

  typedef enum logic [2:0] {IDLE, FILL, PAD, ISSUE, WAIT, LENBLK} state_t;

  state_t      state;
  logic [6:0]  byte_cnt;   // next byte position in the block, 0..64
  logic [63:0] bit_len;    // message length in bits, wraps mod 2^64
  logic        first_flag;
  logic        final_blk;  // block being issued is the last of the message
  logic        need_len;   // a length-only block must follow
  logic        pad_at0;    // that length block also carries the 0x80 marker
  logic [7:0]  hold_cnt;
  logic        done_q;
  logic        take;
  logic        done_rise;

  assign take      = s_valid && s_ready;
  assign done_rise = blk_done && !done_q;

  // Registered copy of the accelerator done level for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= blk_done;
  end

  // Message state machine: byte packing, padding, and block handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= 7'd0;
      bit_len    <= 64'd0;
      first_flag <= 1'b0;
      final_blk  <= 1'b0;
      need_len   <= 1'b0;
      pad_at0    <= 1'b0;
      hold_cnt   <= 8'd0;
      blk_data   <= '0;
      s_ready    <= 1'b0;
      blk_start  <= 1'b0;
      blk_first  <= 1'b0;
      busy       <= 1'b0;
      msg_done   <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (take) begin
            blk_data[0][31:24] <= s_data;
            byte_cnt   <= 7'd1;
            bit_len    <= 64'd8;  // the length already counts this first byte
            first_flag <= 1'b1;
            final_blk  <= 1'b0;
            need_len   <= 1'b0;
            pad_at0    <= 1'b0;
            busy       <= 1'b1;
            if (s_last) begin
              s_ready <= 1'b0;
              state   <= PAD;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (take) begin
            blk_data[byte_cnt[5:2]][{~byte_cnt[1:0], 3'b000} +: 8] <= s_data;
            byte_cnt <= byte_cnt + 7'd1;
            bit_len  <= bit_len + 64'd8;
            if (s_last) begin
              s_ready <= 1'b0;
              state   <= PAD;
            end else if (byte_cnt == 7'd63) begin
              // Full block with more to come: issue it unpadded
              s_ready   <= 1'b0;
              blk_start <= 1'b1;
              blk_first <= first_flag;
              hold_cnt  <= 8'd0;
              state     <= ISSUE;
            end
          end
        end
        PAD: begin
          if (byte_cnt <= 7'd55) begin
            for (int i = 0; i < 56; i++) begin
              if (7'(i) == byte_cnt)
                blk_data[4'(i >> 2)][8*(3 - (i % 4)) +: 8] <= 8'h80;
              else if (7'(i) > byte_cnt)
                blk_data[4'(i >> 2)][8*(3 - (i % 4)) +: 8] <= 8'h00;
            end
            for (int k = 0; k < 8; k++)
              blk_data[4'((56 + k) >> 2)][8*(3 - (k % 4)) +: 8] <= bit_len[8*(7 - k) +: 8];
          end else if (byte_cnt <= 7'd63) begin
            // Marker fits but the length does not: it goes in a second block
            for (int i = 0; i < 64; i++) begin
              if (7'(i) == byte_cnt)
                blk_data[4'(i >> 2)][8*(3 - (i % 4)) +: 8] <= 8'h80;
              else if (7'(i) > byte_cnt)
                blk_data[4'(i >> 2)][8*(3 - (i % 4)) +: 8] <= 8'h00;
            end
          end
          final_blk <= (byte_cnt <= 7'd55);
          need_len  <= (byte_cnt > 7'd55);
          pad_at0   <= (byte_cnt == 7'd64);
          blk_start <= 1'b1;
          blk_first <= first_flag;
          hold_cnt  <= 8'd0;
          state     <= ISSUE;
        end
        ISSUE: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (hold_cnt == 8'(START_HOLD - 1)) begin
            blk_start <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (done_rise) begin
            first_flag <= 1'b0;
            blk_first  <= 1'b0;
            if (final_blk) begin
              msg_done <= 1'b1;
              busy     <= 1'b0;
              s_ready  <= 1'b1;
              state    <= IDLE;
            end else if (need_len) begin
              state <= LENBLK;
            end else begin
              byte_cnt <= 7'd0;
              s_ready  <= 1'b1;
              state    <= FILL;
            end
          end
        end
        LENBLK: begin
          for (int i = 0; i < 56; i++)
            blk_data[4'(i >> 2)][8*(3 - (i % 4)) +: 8] <= (i == 0 && pad_at0) ? 8'h80 : 8'h00;
          for (int k = 0; k < 8; k++)
            blk_data[4'((56 + k) >> 2)][8*(3 - (k % 4)) +: 8] <= bit_len[8*(7 - k) +: 8];
          final_blk <= 1'b1;
          need_len  <= 1'b0;
          pad_at0   <= 1'b0;
          blk_start <= 1'b1;
          blk_first <= first_flag;
          hold_cnt  <= 8'd0;
          state     <= ISSUE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_1_msg_feeder.sv
// tb/tb_sha_1_msg_feeder.sv - randomized bench for sha_1_msg_feeder against a FIPS 180-4 padding model
module tb_sha_1_msg_feeder;

  localparam int START_HOLD = 4;

  typedef logic [7:0] byte_q_t [$];
  typedef logic [15:0][31:0] blk_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  blk_t       blk_data;
  logic       blk_start;
  logic       blk_first;
  logic       blk_done;
  logic       busy;
  logic       msg_done;

  int   checks = 0;
  int   failures = 0;
  blk_t exp_q[$];
  blk_t got_q[$];
  logic got_first_q[$];
  blk_t seen[$];
  bit   stall = 1'b0;
  bit   abort = 1'b0;

  always #5 clk = ~clk;

  sha_1_msg_feeder #(.START_HOLD(START_HOLD)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .blk_data(blk_data), .blk_start(blk_start), .blk_first(blk_first),
    .blk_done(blk_done), .busy(busy), .msg_done(msg_done)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s obs=%0h want=%0h", tag, obs, want);
    end
  endtask

  // Reference: standard SHA padding of the whole message, then cut into 64-byte blocks
  task automatic build_exp(input byte_q_t m);
    byte_q_t     p;
    logic [63:0] bits;
    blk_t        b;
    p = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    exp_q.delete();
    for (int n = 0; n < p.size() / 64; n++) begin
      for (int w = 0; w < 16; w++)
        b[w] = {p[64*n+4*w], p[64*n+4*w+1], p[64*n+4*w+2], p[64*n+4*w+3]};
      exp_q.push_back(b);
    end
  endtask

  task automatic send_bytes(input byte_q_t m, input bit hold);
    int n;
    bit rdy;
    for (int i = 0; i < m.size(); i++) begin
      if (!hold) begin
        while ($urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          s_data  = 8'($urandom);
          s_last  = 1'($urandom);
          @(negedge clk);
        end
      end
      s_valid = 1'b1;
      s_data  = m[i];
      s_last  = (i == m.size() - 1);
      n = 0;
      rdy = s_ready;
      @(negedge clk);
      while (!rdy && n < 4000) begin
        n++;
        rdy = s_ready;
        @(negedge clk);
      end
      if (!rdy) begin
        chk("byte_accept", rdy, 1);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_msg();
    int n = 0;
    int bad_rdy = 0;
    int bad_busy = 0;
    int nblk;
    nblk = exp_q.size();
    while (!msg_done && n < 5000) begin
      if (s_ready) bad_rdy++;
      if (!busy) bad_busy++;
      n++;
      @(negedge clk);
    end
    chk("msg_done_seen", msg_done, 1);
    chk("s_ready_low_until_done", bad_rdy, 0);
    chk("busy_during_msg", bad_busy, 0);
    chk("block_count", got_q.size(), nblk);
    seen = got_q;
    for (int b = 0; b < nblk && got_q.size() > 0; b++) begin
      chk("block_data", got_q.pop_front(), exp_q[b]);
      chk("blk_first", got_first_q.pop_front(), (b == 0));
    end
    got_q.delete();
    got_first_q.delete();
    @(negedge clk);
    chk("msg_done_pulse", msg_done, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic run_msg(input byte_q_t m, input bit hold);
    build_exp(m);
    send_bytes(m, hold);
    finish_msg();
  endtask

  // Accelerator model: records each block on blk_start, answers with a fresh blk_done edge
  initial begin : accel
    blk_t cap;
    logic cap_first;
    int   hold_n;
    bit   keep;
    blk_done = 1'b0;
    forever begin
      @(negedge clk);
      if (blk_start) begin
        keep = 1'($urandom_range(0, 1));
        if (!keep) blk_done = 1'b0;
        cap = blk_data;
        cap_first = blk_first;
        hold_n = 0;
        while (blk_start && hold_n < 64) begin
          hold_n++;
          @(negedge clk);
        end
        chk("start_hold", hold_n, START_HOLD);
        if (keep) begin
          repeat (2) @(negedge clk);
          blk_done = 1'b0;
          @(negedge clk);
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
        while (stall && !abort) @(negedge clk);
        if (abort) begin
          abort = 1'b0;
        end else begin
          chk("blk_data_stable", blk_data, cap);
          chk("blk_first_stable", blk_first, cap_first);
          got_q.push_back(cap);
          got_first_q.push_back(cap_first);
          blk_done = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    byte_q_t m;
    int n;
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_blk_start", blk_start, 0);
    chk("rst_blk_first", blk_first, 0);
    chk("rst_busy", busy, 0);
    chk("rst_msg_done", msg_done, 0);
    chk("rst_blk_data", blk_data, 0);
    reset = 1'b0;
    #1 chk("s_ready_at_release", s_ready, 0);
    @(negedge clk);
    chk("s_ready_after_release", s_ready, 1);

    // "abc"
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 1'b0);
    if (seen.size() >= 1) begin
      chk("abc_w0", seen[0][0], 32'h61626380);
      chk("abc_w15", seen[0][15], 32'h00000018);
    end

    // 55 zero bytes
    m.delete();
    repeat (55) m.push_back(8'h00);
    run_msg(m, 1'b0);
    if (seen.size() >= 1) begin
      chk("z55_w13", seen[0][13], 32'h00000080);
      chk("z55_w15", seen[0][15], 32'h000001B8);
    end

    // 56 zero bytes
    m.push_back(8'h00);
    run_msg(m, 1'b0);
    if (seen.size() >= 2) begin
      chk("z56_b1_w14", seen[0][14], 32'h80000000);
      chk("z56_b1_w15", seen[0][15], 32'h00000000);
      chk("z56_b2_w15", seen[1][15], 32'h000001C0);
    end

    // 64 bytes of 0xFF
    m.delete();
    repeat (64) m.push_back(8'hFF);
    run_msg(m, 1'b1);
    if (seen.size() >= 2) begin
      chk("ff64_b1_w7", seen[0][7], 32'hFFFFFFFF);
      chk("ff64_b2_w0", seen[1][0], 32'h80000000);
      chk("ff64_b2_w15", seen[1][15], 32'h00000200);
    end

    // 130 random bytes with s_valid held high
    m.delete();
    repeat (130) m.push_back(8'($urandom));
    run_msg(m, 1'b1);
    if (seen.size() >= 3) begin
      chk("m130_b3_byte2", seen[2][0][15:8], 8'h80);
      chk("m130_b3_w15", seen[2][15], 32'h00000410);
    end

    // Random lengths, including the padding boundaries
    for (int t = 0; t < 8; t++) begin
      m.delete();
      n = (t < 3) ? (55 + t * 4) : $urandom_range(1, 140);
      repeat (n) m.push_back(8'($urandom));
      run_msg(m, 1'($urandom_range(0, 1)));
    end

    // Reset while waiting for the accelerator
    stall = 1'b1;
    m = '{8'h61, 8'h62, 8'h63};
    build_exp(m);
    send_bytes(m, 1'b0);
    n = 0;
    while (!blk_start && n < 200) begin n++; @(negedge clk); end
    while (blk_start && n < 400) begin n++; @(negedge clk); end
    chk("rst_test_reached_wait", (n < 400), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_s_ready", s_ready, 0);
    chk("arst_blk_start", blk_start, 0);
    chk("arst_blk_first", blk_first, 0);
    chk("arst_busy", busy, 0);
    chk("arst_msg_done", msg_done, 0);
    chk("arst_blk_data", blk_data, 0);
    abort = 1'b1;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst_no_block", got_q.size(), 0);
    chk("arst_s_ready_back", s_ready, 1);
    run_msg(m, 1'b0);
    if (seen.size() >= 1) begin
      chk("abc2_w0", seen[0][0], 32'h61626380);
      chk("abc2_w15", seen[0][15], 32'h00000018);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
